// File: rtl/sd_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_clk_pkg
// Description : Shared types and constants for the SD card clock generator.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_clk_pkg;

  // Clock generator FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } sd_clk_state_e;

  // System clock frequency the divisors are expressed against
  localparam int unsigned SYS_CLK_HZ = 50_000_000;

  // 400 kHz identification clock at 50 MHz
  localparam logic [15:0] DEF_INIT_DIV = 16'd125;

  // Shortest period that still yields one high and one low cycle
  localparam logic [15:0] DEF_MIN_DIV = 16'd2;

endpackage : sd_clk_pkg
`default_nettype wire

// File: rtl/sd_clk_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : sd_clk_generator_if
// Description : Control/status bundle between the divide-count source, the
//               SD clock generator and the SD bus front end.
// Revision    : 1.0 - initial release
// ============================================================================
interface sd_clk_generator_if;

  logic        en;
  logic [16:0] div_in;
  logic        sd_clk;
  logic        rise_stb;
  logic        fall_stb;
  logic        running;
  logic [15:0] div_active;

  // Side that requests the clock and supplies the divisor
  modport master (
    output en,
    output div_in,
    input  sd_clk,
    input  rise_stb,
    input  fall_stb,
    input  running,
    input  div_active
  );

  // The clock generator itself
  modport slave (
    input  en,
    input  div_in,
    output sd_clk,
    output rise_stb,
    output fall_stb,
    output running,
    output div_active
  );

endinterface : sd_clk_generator_if
`default_nettype wire

// File: rtl/sd_clk_generator_reg.sv
`default_nettype none
// ============================================================================
// Module      : sd_clk_generator_reg
// Description : Load-enabled holding register with synchronous active-low
//               reset to a configurable value.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_clk_generator_reg #(
  parameter int unsigned       WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] d,
  output logic      [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Capture d when load is asserted; reset restores the default value
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= RESET_VAL;
    end else if (load) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule : sd_clk_generator_reg
`default_nettype wire

// File: rtl/sd_clk_generator.sv
`default_nettype none
// ============================================================================
// Module      : sd_clk_generator
// Description : Glitch-free SD card clock with rise/fall strobes. The period
//               is selected from div_in (or INIT_DIV), clamped to MIN_DIV and
//               latched only at the start of each period; the clock always
//               completes its current period and stops low.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_clk_generator
  import sd_clk_pkg::*;
#(
  parameter logic [15:0] INIT_DIV = DEF_INIT_DIV,
  parameter logic [15:0] MIN_DIV  = DEF_MIN_DIV
) (
  input  wire logic           clk,
  input  wire logic           reset,
  sd_clk_generator_if.slave   bus
);

  sd_clk_state_e r_state;
  logic [15:0]   r_cnt;
  logic          r_sd_clk;
  logic          r_rise_stb;
  logic          r_fall_stb;
  logic          r_running;

  logic [15:0]   w_sel;
  logic [15:0]   w_period;
  logic [15:0]   w_high_new;
  logic [15:0]   w_low_len;
  logic [15:0]   w_div_active;
  logic          w_cnt_last;
  logic          w_start;

  // Divisor select and clamp, evaluated every cycle but only used at a rise
  assign w_sel      = bus.div_in[16] ? bus.div_in[15:0] : INIT_DIV;
  assign w_period   = (w_sel < MIN_DIV) ? MIN_DIV : w_sel;
  assign w_high_new = w_period >> 1;

  // Low phase takes the odd cycle, and comes from the period already latched
  assign w_low_len  = w_div_active - (w_div_active >> 1);

  assign w_cnt_last = (r_cnt == 16'd1);

  // A new period begins from IDLE, or seamlessly at the end of LOW
  assign w_start    = bus.en &&
                      ((r_state == ST_IDLE) ||
                       ((r_state == ST_LOW) && w_cnt_last));

  sd_clk_generator_reg #(
    .WIDTH     (16),
    .RESET_VAL (INIT_DIV)
  ) u_div_active_reg (
    .clk   (clk),
    .reset (reset),
    .load  (w_start),
    .d     (w_period),
    .q     (w_div_active)
  );

  // Phase FSM with down-counter; all outputs registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 16'd0;
      r_sd_clk   <= 1'b0;
      r_rise_stb <= 1'b0;
      r_fall_stb <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_rise_stb <= 1'b0;
      r_fall_stb <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.en) begin
            r_state    <= ST_HIGH;
            r_cnt      <= w_high_new;
            r_sd_clk   <= 1'b1;
            r_rise_stb <= 1'b1;
            r_running  <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (w_cnt_last) begin
            r_state    <= ST_LOW;
            r_cnt      <= w_low_len;
            r_sd_clk   <= 1'b0;
            r_fall_stb <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        ST_LOW: begin
          if (w_cnt_last) begin
            if (bus.en) begin
              r_state    <= ST_HIGH;
              r_cnt      <= w_high_new;
              r_sd_clk   <= 1'b1;
              r_rise_stb <= 1'b1;
            end else begin
              r_state   <= ST_IDLE;
              r_cnt     <= 16'd0;
              r_running <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= 16'd0;
          r_sd_clk  <= 1'b0;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sd_clk     = r_sd_clk;
  assign bus.rise_stb   = r_rise_stb;
  assign bus.fall_stb   = r_fall_stb;
  assign bus.running    = r_running;
  assign bus.div_active = w_div_active;

endmodule : sd_clk_generator
`default_nettype wire

// File: tb/tb_sd_clk_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_clk_generator
// Description : Self-checking bench for sd_clk_generator. A period-position
//               reference model (time since period start, latched period)
//               predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_clk_generator;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  sd_clk_generator_if bus();

  sd_clk_generator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position within the current period and its length
  bit m_run = 1'b0;
  int m_t   = 0;
  int m_p   = 125;

  function automatic int eff_period(logic [16:0] d);
    int s;
    s = d[16] ? int'(d[15:0]) : 125;
    return (s < 2) ? 2 : s;
  endfunction

  // Period advances one cycle per clock; a new period picks up div_in
  always @(posedge clk) begin
    if (!reset) begin
      m_run <= 1'b0;
      m_t   <= 0;
      m_p   <= 125;
    end else if (!m_run) begin
      if (bus.en) begin
        m_run <= 1'b1;
        m_t   <= 0;
        m_p   <= eff_period(bus.div_in);
      end
    end else if (m_t == m_p - 1) begin
      if (bus.en) begin
        m_t <= 0;
        m_p <= eff_period(bus.div_in);
      end else begin
        m_run <= 1'b0;
        m_t   <= 0;
      end
    end else begin
      m_t <= m_t + 1;
    end
  end

  function automatic logic [19:0] exp_vec();
    logic c, r, f;
    c = m_run && (m_t < m_p / 2);
    r = m_run && (m_t == 0);
    f = m_run && (m_t == m_p / 2);
    return {c, r, f, m_run, 16'(m_p)};
  endfunction

  function automatic logic [19:0] act_vec();
    return {bus.sd_clk, bus.rise_stb, bus.fall_stb, bus.running, bus.div_active};
  endfunction

  task automatic do_reset(int n);
    reset = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [19:0] idle_vec;
    idle_vec = {4'b0000, 16'd125};
    reset = 1'b0;
    bus.en = 1'b1;
    bus.div_in = 17'h0_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (act_vec() !== idle_vec) begin
        n_fail++;
        $display("FAIL reset_state cyc=%0d actual=%h required=%h", i, act_vec(), idle_vec);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_default();
    int highs;
    int rises;
    highs = 0;
    rises = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL default_model cyc=%0d actual=%h required=%h", i, act_vec(), exp_vec());
      end
      if (i == 0) begin
        n_checks++;
        if (bus.rise_stb !== 1'b1) begin
          n_fail++;
          $display("FAIL default_first_rise actual=%b required=1", bus.rise_stb);
        end
      end
      if (i < 125 && bus.sd_clk === 1'b1) highs++;
      if (i < 250 && bus.rise_stb === 1'b1) rises++;
    end
    n_checks++;
    if (highs != 62) begin
      n_fail++;
      $display("FAIL default_high_len actual=%0d required=62", highs);
    end
    n_checks++;
    if (rises != 2) begin
      n_fail++;
      $display("FAIL default_rise_count actual=%0d required=2", rises);
    end
  endtask

  task automatic test_p2(input logic [15:0] req, input string name);
    bus.en = 1'b1;
    bus.div_in = {1'b1, req};
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL %s_model cyc=%0d actual=%h required=%h", name, i, act_vec(), exp_vec());
      end
      n_checks++;
      if ((bus.rise_stb ^ bus.fall_stb) !== 1'b1 || bus.sd_clk !== ((i % 2) == 0) ||
          bus.div_active !== 16'd2) begin
        n_fail++;
        $display("FAIL %s_toggle cyc=%0d actual=clk%b r%b f%b div%0d required=clk%b div2",
                 name, i, bus.sd_clk, bus.rise_stb, bus.fall_stb, bus.div_active, (i % 2) == 0);
      end
    end
  endtask

  task automatic wait_rise(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.rise_stb === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_rise_timeout actual=no_rise required=rise", name);
    end
  endtask

  task automatic test_midchange();
    logic exp_clk;
    bus.en = 1'b1;
    bus.div_in = {1'b1, 16'd10};
    do_reset(1);
    wait_rise("midchange");
    for (int i = 1; i < 18; i++) begin
      @(negedge clk);
      if (i == 3) bus.div_in = {1'b1, 16'd7};
      exp_clk = (i < 5) || (i >= 10 && i < 13) || (i == 17);
      n_checks++;
      if (act_vec() !== exp_vec() || bus.sd_clk !== exp_clk) begin
        n_fail++;
        $display("FAIL midchange cyc=%0d actual=%h clk=%b required=%h clk=%b",
                 i, act_vec(), bus.sd_clk, exp_vec(), exp_clk);
      end
    end
  endtask

  task automatic test_en_drop();
    int highs, falls, rises, runs;
    highs = 0; falls = 0; rises = 0; runs = 0;
    bus.en = 1'b1;
    bus.div_in = {1'b1, 16'd10};
    do_reset(1);
    wait_rise("en_drop");
    @(negedge clk);
    bus.en = 1'b0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL en_drop_model cyc=%0d actual=%h required=%h", j, act_vec(), exp_vec());
      end
      if (bus.sd_clk === 1'b1) highs++;
      if (bus.fall_stb === 1'b1) falls++;
      if (bus.rise_stb === 1'b1) rises++;
      if (bus.running === 1'b1) runs++;
    end
    n_checks++;
    if (highs != 3 || falls != 1 || rises != 0 || runs != 8 ||
        bus.running !== 1'b0 || bus.sd_clk !== 1'b0) begin
      n_fail++;
      $display("FAIL en_drop_counts actual=h%0d f%0d r%0d run%0d end_run%b end_clk%b required=h3 f1 r0 run8 end_run0 end_clk0",
               highs, falls, rises, runs, bus.running, bus.sd_clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] idle_vec;
    idle_vec = {4'b0000, 16'd125};
    bus.en = 1'b1;
    bus.div_in = {1'b1, 16'd10};
    do_reset(1);
    wait_rise("reset_mid");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (act_vec() !== idle_vec || act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_mid actual=%h required=%h", act_vec(), idle_vec);
    end
    reset = 1'b1;
    bus.en = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc=%0d actual=%h required=%h", i, act_vec(), exp_vec());
      end
      n_checks++;
      if (bus.rise_stb === 1'b1 && bus.fall_stb === 1'b1) begin
        n_fail++;
        $display("FAIL random_strobes cyc=%0d actual=both required=exclusive", i);
      end
      reset      = ($urandom_range(0, 299) != 0);
      bus.en     = ($urandom_range(0, 9) != 0);
      bus.div_in = {($urandom_range(0, 15) != 0), 16'($urandom_range(0, 12))};
    end
    reset = 1'b1;
  endtask

  initial begin
    bus.en = 1'b0;
    bus.div_in = 17'h0_0000;
    test_reset();
    test_default();
    test_p2(16'd2, "p2");
    test_p2(16'd0, "clamp0");
    test_p2(16'd1, "clamp1");
    test_midchange();
    test_en_drop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sd_clk_generator
`default_nettype wire
